music_rom_sequencer: RTL and testbench

//  Plays a song stored in a synchronous block ROM of note words (1-cycle registered read, read enable).

---
 rtl/music_rom_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_music_rom_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_rom_sequencer.sv
// rtl/music_rom_sequencer.sv - ROM-driven note sequencer feeding a tone generator
// Optional feature macro: MUSIC_SEQ_GAP_EN (silent articulation gap between notes)
module music_rom_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 12,
  parameter int BEAT_DIV   = 3125000,
  parameter int START_ADDR = 0,
  parameter int GAP_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  pause_i,
  input  logic                  loop_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [7:0]            note_o,
  output logic                  note_vld_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_PLAY   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam int                    PW         = $clog2(BEAT_DIV);
  localparam logic [PW-1:0]         PRESC_LAST = PW'(BEAT_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] START      = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [DATA_WIDTH-1:0] END_MARK   = DATA_WIDTH'(12'hFFF);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic [7:0]              note_q, note_d;
  logic                    vld_q, vld_d;
  logic                    done_q, done_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [4:0]              beats_q, beats_d;
  logic [7:0]              word_pitch;
  logic [3:0]              word_beats;

`ifdef MUSIC_SEQ_GAP_EN
  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  logic [GW-1:0]            gap_q, gap_d;
`endif

  assign word_pitch = rom_data_i[11:4];
  assign word_beats = rom_data_i[3:0];

  assign rom_en_o   = (state_q == S_FETCH);
  assign rom_addr_o = rom_addr_q;
  assign note_o     = note_q;
  assign note_vld_o = vld_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;

  // Next-state and output decode; stop_i overrides every state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    note_d  = note_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    presc_d = presc_q;
    beats_d = beats_q;
`ifdef MUSIC_SEQ_GAP_EN
    gap_d   = gap_q;
`endif
    if (stop_i) begin
      state_d = S_IDLE;
      note_d  = 8'd0;
      vld_d   = 1'b0;
      presc_d = '0;
      beats_d = 5'd0;
`ifdef MUSIC_SEQ_GAP_EN
      gap_d   = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d = S_FETCH;
            ptr_d   = START;
          end
        end
        S_FETCH: begin
          state_d = S_DECODE;
        end
        S_DECODE: begin
          if (rom_data_i == END_MARK) begin
            if (loop_i) begin
              ptr_d   = START;
              state_d = S_FETCH;
            end else begin
              done_d  = 1'b1;
              state_d = S_IDLE;
              note_d  = 8'd0;
              vld_d   = 1'b0;
            end
          end else begin
            note_d  = word_pitch;
            vld_d   = (word_pitch != 8'd0);
            beats_d = (word_beats == 4'd0) ? 5'd16 : {1'b0, word_beats};
            presc_d = '0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause_i) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              beats_d = beats_q - 5'd1;
              if (beats_q == 5'd1) begin
                if (ptr_q == LAST_ADDR) begin
                  // Top of the address space ends the song rather than wrapping.
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  note_d  = 8'd0;
                  vld_d   = 1'b0;
                end else begin
                  ptr_d = ptr_q + 1'b1;
`ifdef MUSIC_SEQ_GAP_EN
                  state_d = S_GAP;
                  note_d  = 8'd0;
                  vld_d   = 1'b0;
                  gap_d   = '0;
`else
                  state_d = S_FETCH;
`endif
                end
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
`ifdef MUSIC_SEQ_GAP_EN
        S_GAP: begin
          if (!pause_i) begin
            if (gap_q == GAP_LAST) begin
              gap_d   = '0;
              state_d = S_FETCH;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, pointer and output registers; the address register mirrors the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= START;
      rom_addr_q <= START;
      note_q     <= 8'd0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      beats_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= ptr_d;
      note_q     <= note_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      beats_q    <= beats_d;
    end
  end

`ifdef MUSIC_SEQ_GAP_EN
  // Silent-gap counter between notes.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

endmodule

// File: tb/tb_music_rom_sequencer.sv
// tb/tb_music_rom_sequencer.sv - randomized self-checking bench for music_rom_sequencer
module tb_music_rom_sequencer;

  localparam int AW   = 4;
  localparam int BD   = 4;
  localparam int MAXC = 1200;
`ifdef MUSIC_SEQ_GAP_EN
  localparam int GAP  = 3;
`else
  localparam int GAP  = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          pause_i = 1'b0;
  logic          loop_i = 1'b0;
  logic          rom_en_o;
  logic [AW-1:0] rom_addr_o;
  logic [11:0]   rom_data_i;
  logic [7:0]    note_o;
  logic          note_vld_o;
  logic          busy_o;
  logic          done_o;

  logic [11:0]   rom [0:15];
  logic [15:0]   obs [0:MAXC-1];
  logic [15:0]   expv [0:MAXC-1];
  int            n_cmp = 0;
  int            n_err = 0;

  music_rom_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(12), .BEAT_DIV(BD), .START_ADDR(0), .GAP_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .pause_i(pause_i),
    .loop_i(loop_i), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .note_o(note_o), .note_vld_o(note_vld_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_en_o) rom_data_i <= rom[rom_addr_o];
  end

  // Packed snapshot: busy, done, vld, note, en, address (only meaningful while en).
  function automatic logic [15:0] pack(input logic b, input logic d, input logic v,
                                       input logic [7:0] n, input logic e, input logic [3:0] a);
    return {b, d, v, n, e, (e ? a : 4'd0)};
  endfunction

  function automatic logic [15:0] sample();
    return pack(busy_o, done_o, note_vld_o, note_o, rom_en_o, rom_addr_o);
  endfunction

  // Reference: walk the song note by note and lay the expected outputs onto a cycle timeline.
  // Cycle 0 carries the start pulse; ps/pl describe a pause window placed inside one note.
  task automatic build(input bit lp, input int ps, input int pl);
    int t, addr, len, b;
    logic [7:0] cn;
    logic cv;
    logic [11:0] w;
    for (int i = 0; i < MAXC; i++) expv[i] = 16'd0;
    t = 1; addr = 0; cn = 8'd0; cv = 1'b0;
    while (t < MAXC - 2) begin
      expv[t]   = pack(1'b1, 1'b0, cv, cn, 1'b1, addr[3:0]);
      expv[t+1] = pack(1'b1, 1'b0, cv, cn, 1'b0, 4'd0);
      w = rom[addr];
      t += 2;
      if (w == 12'hFFF) begin
        if (lp) begin
          addr = 0;
          continue;
        end
        expv[t] = pack(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
        break;
      end
      cn  = w[11:4];
      cv  = (cn != 8'd0);
      b   = (w[3:0] == 4'd0) ? 16 : int'(w[3:0]);
      len = b * BD;
      if (pl > 0 && ps >= t && ps < t + len) len += pl;
      for (int i = 0; i < len && t + i < MAXC; i++) expv[t+i] = pack(1'b1, 1'b0, cv, cn, 1'b0, 4'd0);
      t += len;
      if (t >= MAXC) break;
      if (addr == 15) begin
        expv[t] = pack(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 4'd0);
        break;
      end
      addr++;
      if (GAP > 0) begin
        for (int i = 0; i < GAP && t + i < MAXC; i++) expv[t+i] = pack(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0);
        cn = 8'd0; cv = 1'b0; t += GAP;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_i = 1'b0; loop_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one playback and records the observed outputs for h cycles.
  task automatic play(input bit lp, input int ps, input int pl, input int h);
    loop_i = lp;
    @(posedge clk);
    #1 start_i = 1'b1;
    obs[0] = sample();
    for (int k = 1; k < h; k++) begin
      @(posedge clk);
      #1;
      start_i = 1'b0;
      pause_i = (pl > 0 && k >= ps && k < ps + pl);
      obs[k] = sample();
    end
    pause_i = 1'b0;
    loop_i  = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) rom[i] = 12'hFFF;
    rom[0] = 12'h452; rom[1] = 12'h001; rom[2] = 12'hFFF;
  endtask

  task automatic test_reset();
    load_basic();
    do_reset();
    #1;
    n_cmp++;
    if ({busy_o, done_o, note_vld_o, note_o, rom_en_o, rom_addr_o} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h want 0000", {busy_o, done_o, note_vld_o, note_o, rom_en_o, rom_addr_o});
    end
    play(1'b0, 0, 0, 8);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({busy_o, done_o, note_vld_o, note_o, rom_en_o, rom_addr_o} !== 16'd0) begin
      n_err++;
      $display("FAIL reset_midplay: got %h want 0000", {busy_o, done_o, note_vld_o, note_o, rom_en_o, rom_addr_o});
    end
  endtask

  task automatic test_basic_song();
    int ndone;
    load_basic();
    do_reset();
    build(1'b0, 0, 0);
    play(1'b0, 0, 0, 40);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++;
        $display("FAIL basic_song cyc %0d: got %h want %h", k, obs[k], expv[k]);
      end
      if (obs[k][14]) ndone++;
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_err++;
      $display("FAIL basic_done_count: got %0d want 1", ndone);
    end
  endtask

  task automatic test_long_note();
    for (int i = 0; i < 16; i++) rom[i] = 12'hFFF;
    rom[0] = 12'h120;
    do_reset();
    build(1'b0, 0, 0);
    play(1'b0, 0, 0, 80);
    for (int k = 0; k < 80; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++;
        $display("FAIL long_note cyc %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_loop();
    load_basic();
    do_reset();
    build(1'b1, 0, 0);
    play(1'b1, 0, 0, 90);
    for (int k = 0; k < 90; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++;
        $display("FAIL loop cyc %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_pause();
    load_basic();
    do_reset();
    build(1'b0, 5, 10);
    play(1'b0, 5, 10, 50);
    for (int k = 0; k < 50; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++;
        $display("FAIL pause cyc %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
  endtask

  task automatic test_stop();
    load_basic();
    do_reset();
    @(posedge clk);
    #1 start_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    n_cmp++;
    if ({busy_o, note_vld_o, note_o} !== {1'b1, 1'b1, 8'h45}) begin
      n_err++;
      $display("FAIL stop_pre_playing: got %h want 1145", {busy_o, note_vld_o, note_o});
    end
    stop_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 stop_i = 1'b0; start_i = 1'b0;
    n_cmp++;
    if ({busy_o, done_o, note_vld_o, note_o, rom_en_o} !== 12'd0) begin
      n_err++;
      $display("FAIL stop_in_play: got %h want 000", {busy_o, done_o, note_vld_o, note_o, rom_en_o});
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy_o, done_o, note_vld_o} !== 3'd0) begin
        n_err++;
        $display("FAIL stop_stays_idle cyc %0d: got %b want 000", k, {busy_o, done_o, note_vld_o});
      end
    end
    stop_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 stop_i = 1'b0; start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({busy_o, rom_en_o, done_o} !== 3'd0) begin
        n_err++;
        $display("FAIL start_stop_idle cyc %0d: got %b want 000", k, {busy_o, rom_en_o, done_o});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_no_marker();
    for (int i = 0; i < 16; i++) rom[i] = 12'h011;
    do_reset();
    build(1'b0, 0, 0);
    play(1'b0, 0, 0, 170);
    for (int k = 0; k < 170; k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++;
        $display("FAIL no_marker cyc %0d: got %h want %h", k, obs[k], expv[k]);
      end
    end
    n_cmp++;
    if (rom_addr_o !== 4'd15) begin
      n_err++;
      $display("FAIL no_wrap_addr: got %0d want 15", rom_addr_o);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < 16; i++) begin
        rom[i] = 12'($urandom_range(0, 4095));
        if (rom[i] == 12'hFFF) rom[i] = 12'hFFE;
      end
      rom[n] = 12'hFFF;
      do_reset();
      build(1'b0, 0, 0);
      play(1'b0, 0, 0, 480);
      for (int k = 0; k < 480; k++) begin
        n_cmp++;
        if (obs[k] !== expv[k]) begin
          n_err++;
          $display("FAIL random%0d cyc %0d: got %h want %h", r, k, obs[k], expv[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_song();
    test_long_note();
    test_loop();
    test_pause();
    test_stop();
    test_no_marker();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
